// File: rtl/booth_acc_pkg.sv
// Shared types for the Booth product accumulator.
// Default widths match the reference multiplier configuration.
package booth_acc_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ACC_W = 24;
  localparam int DEF_CNT_W = 8;

  typedef logic [2*DEF_WIDTH-1:0] prod_t;
  typedef logic [DEF_ACC_W-1:0]   acc_t;

  typedef struct packed {
    acc_t                 sum;
    logic [DEF_CNT_W-1:0] cnt;
    logic                 ovf;
  } res_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } fifo_st_t;

endpackage

// File: rtl/booth_res_fifo2.sv
// Two-entry valid/ready result buffer.
// Flags a drop when a push meets a full buffer with no pop.
module booth_res_fifo2
  import booth_acc_pkg::*;
#(
  parameter type T = res_t
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic push,
  input  T     din,
  output logic valid,
  input  logic ready,
  output T     dout,
  output logic drop
);

  fifo_st_t st, st_n;
  T         head, head_n;
  T         tail, tail_n;
  logic     pop;

  assign valid = (st != EMPTY);
  assign pop   = valid & ready;
  assign dout  = head;

  // Next state, next entries and drop pulse.
  always_comb begin
    st_n   = st;
    head_n = head;
    tail_n = tail;
    drop   = 1'b0;
    unique case (st)
      EMPTY: begin
        if (push) begin
          st_n   = ONE;
          head_n = din;
        end
      end
      ONE: begin
        unique case (1'b1)
          push & pop:  head_n = din;
          push & ~pop: begin
            st_n   = FULL;
            tail_n = din;
          end
          ~push & pop: st_n = EMPTY;
          default: ;
        endcase
      end
      FULL: begin
        unique case (1'b1)
          push & pop: begin
            head_n = tail;
            tail_n = din;
          end
          push & ~pop: drop = 1'b1;
          ~push & pop: begin
            st_n   = ONE;
            head_n = tail;
          end
          default: ;
        endcase
      end
      default: st_n = EMPTY;
    endcase
  end

  // State and entry registers; clr empties the buffer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st   <= EMPTY;
      head <= '0;
      tail <= '0;
    end else if (clr) begin
      st   <= EMPTY;
      head <= '0;
      tail <= '0;
    end else begin
      st   <= st_n;
      head <= head_n;
      tail <= tail_n;
    end
  end

endmodule

// File: rtl/booth_prod_accum.sv
// Dot-product accumulator behind the Booth multiplier.
// Tags ride a delay line aligned with the product stream.
module booth_prod_accum
  import booth_acc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 2,
  parameter int ACC_W   = 24,
  parameter int CNT_W   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               clr,
  input  logic               op_valid,
  input  logic               op_last,
  input  logic [2*WIDTH-1:0] product,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ACC_W-1:0]   res_sum,
  output logic [CNT_W-1:0]   res_cnt,
  output logic               res_ovf,
  output logic               drop_err
);

  localparam int PADW = ACC_W + 1 - 2*WIDTH;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } rw_t;

  logic [MUL_LAT-1:0] v_pipe, l_pipe;
  logic               t_v, t_l;

  logic [ACC_W-1:0]   acc, base, acc_n;
  logic [ACC_W:0]     sum_w;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               ovf_g, ovf_n, carry;
  logic               first;
  logic               push, drop;
  rw_t                din, dout;

  assign t_v = v_pipe[MUL_LAT-1];
  assign t_l = l_pipe[MUL_LAT-1];

  // Delay valid/last to the cycle their product appears.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v_pipe <= '0;
      l_pipe <= '0;
    end else if (clr) begin
      v_pipe <= '0;
      l_pipe <= '0;
    end else begin
      v_pipe[0] <= op_valid;
      l_pipe[0] <= op_valid & op_last;
      for (int i = 1; i < MUL_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        l_pipe[i] <= l_pipe[i-1];
      end
    end
  end

  // Next sum, wrap carry and saturating term count.
  always_comb begin
    base  = first ? '0 : acc;
    sum_w = {1'b0, base} + {{PADW{1'b0}}, product};
    carry = sum_w[ACC_W];
    acc_n = sum_w[ACC_W-1:0];
    ovf_n = (first ? 1'b0 : ovf_g) | carry;
    if (first)
      cnt_n = CNT_W'(1);
    else if (&cnt)
      cnt_n = cnt;
    else
      cnt_n = cnt + CNT_W'(1);
  end

  // Group accumulator; first marks the start of a group.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_g <= 1'b0;
      first <= 1'b1;
    end else if (clr) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_g <= 1'b0;
      first <= 1'b1;
    end else if (t_v) begin
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf_g <= ovf_n;
      first <= t_l;
    end
  end

  assign push     = t_v & t_l;
  assign din.sum  = acc_n;
  assign din.cnt  = cnt_n;
  assign din.ovf  = ovf_n;

  booth_res_fifo2 #(
    .T (rw_t)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (clr),
    .push  (push),
    .din   (din),
    .valid (res_valid),
    .ready (res_ready),
    .dout  (dout),
    .drop  (drop)
  );

  assign res_sum = dout.sum;
  assign res_cnt = dout.cnt;
  assign res_ovf = dout.ovf;

  // Sticky drop flag, cleared only by reset or clr.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      drop_err <= 1'b0;
    else if (clr)
      drop_err <= 1'b0;
    else if (drop)
      drop_err <= 1'b1;
  end

endmodule

// File: tb/tb_booth_prod_accum.sv
// Directed bench for booth_prod_accum (24- and 16-bit sums).
// Models the multiplier as a MUL_LAT-deep product pipe.
module tb_booth_prod_accum;

  localparam int L = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        clr;
  logic        op_valid;
  logic        op_last;
  logic        res_ready;
  logic [7:0]  a_in, b_in;
  logic [15:0] mp [L];
  logic [15:0] product;

  logic        v24, o24, d24;
  logic [23:0] s24;
  logic [7:0]  c24;
  logic        v16, o16, d16;
  logic [15:0] s16;
  logic [7:0]  c16;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    mp[0] <= 16'(a_in) * 16'(b_in);
    for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
  end
  assign product = mp[L-1];

  booth_prod_accum #(
    .WIDTH(8), .MUL_LAT(L), .ACC_W(24), .CNT_W(8)
  ) u24 (
    .CLK(CLK), .RST(RST), .clr(clr),
    .op_valid(op_valid), .op_last(op_last),
    .product(product), .res_valid(v24),
    .res_ready(res_ready), .res_sum(s24),
    .res_cnt(c24), .res_ovf(o24), .drop_err(d24)
  );

  booth_prod_accum #(
    .WIDTH(8), .MUL_LAT(L), .ACC_W(16), .CNT_W(8)
  ) u16 (
    .CLK(CLK), .RST(RST), .clr(clr),
    .op_valid(op_valid), .op_last(op_last),
    .product(product), .res_valid(v16),
    .res_ready(res_ready), .res_sum(s16),
    .res_cnt(c16), .res_ovf(o16), .drop_err(d16)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic op(input logic v, input logic l,
                    input logic [7:0] a,
                    input logic [7:0] b);
    op_valid = v;
    op_last  = l;
    a_in     = a;
    b_in     = b;
    tick();
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  initial begin
    RST = 1'b1; clr = 1'b0; res_ready = 1'b0;
    op_valid = 1'b0; op_last = 1'b0;
    a_in = 8'd0; b_in = 8'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_valid", 32'(v24), 32'd0);
    chk("rst_sum",   32'(s24), 32'd0);
    chk("rst_drop",  32'(d24), 32'd0);
    RST = 1'b0;
    tick();

    // Group 25, then async reset mid-cycle
    op(1'b1, 1'b1, 8'd5, 8'd5);
    idle();
    chk("lat_early", 32'(v24), 32'd0);
    idle();
    chk("lat_valid", 32'(v24), 32'd1);
    chk("g25_sum",   32'(s24), 32'd25);
    #3 RST = 1'b1;
    #1;
    chk("arst_valid", 32'(v24), 32'd0);
    chk("arst_sum",   32'(s24), 32'd0);
    chk("arst_cnt",   32'(c24), 32'd0);
    chk("arst_ovf",   32'(o24), 32'd0);
    chk("arst_drop",  32'(d24), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;

    // (2,3,last) after reset
    op(1'b1, 1'b1, 8'd2, 8'd3);
    idle();
    idle();
    chk("g6_valid", 32'(v24), 32'd1);
    chk("g6_sum",   32'(s24), 32'd6);
    chk("g6_cnt",   32'(c24), 32'd1);
    res_ready = 1'b1;
    idle();
    res_ready = 1'b0;
    chk("g6_pop", 32'(v24), 32'd0);

    // 3-term group, then back-to-back 1-term group
    op(1'b1, 1'b0, 8'd3, 8'd5);
    op(1'b1, 1'b0, 8'd7, 8'd9);
    op(1'b1, 1'b1, 8'd255, 8'd255);
    op(1'b1, 1'b1, 8'd1, 8'd1);
    chk("g3_early", 32'(v24), 32'd0);
    idle();
    chk("g3_valid", 32'(v24), 32'd1);
    chk("g3_sum",   32'(s24), 32'd65103);
    chk("g3_cnt",   32'(c24), 32'd3);
    chk("g3_ovf",   32'(o24), 32'd0);
    res_ready = 1'b1;
    idle();
    chk("g1_valid", 32'(v24), 32'd1);
    chk("g1_sum",   32'(s24), 32'd1);
    chk("g1_cnt",   32'(c24), 32'd1);
    idle();
    chk("g1_pop", 32'(v24), 32'd0);
    res_ready = 1'b0;

    // Overflow on the 16-bit instance
    op(1'b1, 1'b0, 8'd255, 8'd255);
    op(1'b1, 1'b1, 8'd255, 8'd255);
    op(1'b1, 1'b1, 8'd2, 8'd2);
    idle();
    chk("ov16_valid", 32'(v16), 32'd1);
    chk("ov16_sum",   32'(s16), 32'hFC02);
    chk("ov16_ovf",   32'(o16), 32'd1);
    chk("ov16_cnt",   32'(c16), 32'd2);
    chk("ov24_sum",   32'(s24), 32'h1FC02);
    chk("ov24_ovf",   32'(o24), 32'd0);
    res_ready = 1'b1;
    idle();
    chk("nx16_sum", 32'(s16), 32'd4);
    chk("nx16_ovf", 32'(o16), 32'd0);
    chk("nx16_cnt", 32'(c16), 32'd1);
    idle();
    chk("nx16_pop", 32'(v16), 32'd0);
    res_ready = 1'b0;

    // Backpressure: third result dropped
    op(1'b1, 1'b1, 8'd1, 8'd1);
    op(1'b1, 1'b1, 8'd2, 8'd2);
    op(1'b1, 1'b1, 8'd3, 8'd3);
    chk("bp_one", 32'(v24), 32'd1);
    idle();
    chk("bp_full_sum",  32'(s24), 32'd1);
    chk("bp_full_drop", 32'(d24), 32'd0);
    idle();
    chk("bp_drop",     32'(d24), 32'd1);
    chk("bp_hold_sum", 32'(s24), 32'd1);
    chk("bp_hold_cnt", 32'(c24), 32'd1);
    res_ready = 1'b1;
    idle();
    chk("bp_pop2_valid", 32'(v24), 32'd1);
    chk("bp_pop2_sum",   32'(s24), 32'd4);
    idle();
    chk("bp_empty", 32'(v24), 32'd0);
    chk("bp_sticky", 32'(d24), 32'd1);
    res_ready = 1'b0;

    // clr clears drop_err
    clr = 1'b1;
    idle();
    clr = 1'b0;
    chk("clr_drop", 32'(d24), 32'd0);

    // FULL with push and pop together
    op(1'b1, 1'b1, 8'd5, 8'd5);
    op(1'b1, 1'b1, 8'd6, 8'd6);
    op(1'b1, 1'b1, 8'd7, 8'd7);
    idle();
    chk("fpp_head", 32'(s24), 32'd25);
    res_ready = 1'b1;
    idle();
    res_ready = 1'b0;
    chk("fpp_sum1", 32'(s24), 32'd36);
    chk("fpp_nodrop", 32'(d24), 32'd0);
    res_ready = 1'b1;
    idle();
    chk("fpp_sum2", 32'(s24), 32'd49);
    chk("fpp_valid2", 32'(v24), 32'd1);
    idle();
    chk("fpp_empty", 32'(v24), 32'd0);
    chk("fpp_drop", 32'(d24), 32'd0);
    res_ready = 1'b0;

    // clr mid-group with a buffered result pending
    op(1'b1, 1'b1, 8'd4, 8'd4);
    idle();
    idle();
    chk("cm_pending", 32'(s24), 32'd16);
    op(1'b1, 1'b0, 8'd10, 8'd10);
    idle();
    idle();
    clr = 1'b1;
    op(1'b1, 1'b1, 8'd9, 8'd9);
    clr = 1'b0;
    chk("cm_flush", 32'(v24), 32'd0);
    op(1'b1, 1'b1, 8'd2, 8'd2);
    idle();
    chk("cm_nospur", 32'(v24), 32'd0);
    idle();
    chk("cm_valid", 32'(v24), 32'd1);
    chk("cm_sum",   32'(s24), 32'd4);
    chk("cm_cnt",   32'(c24), 32'd1);
    chk("cm_ovf",   32'(o24), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/booth_prod_accum.md
Name: booth_prod_accum

Overview:
- Downstream neighbour of the radix-8 Booth multiplier top (mb8_top); consumes its 2*WIDTH-bit `product` stream.
- The multiplier has no valid/stall signals, so this block carries operand valid/last tags through a delay line of MUL_LAT stages that matches the multiplier pipeline.
- It accumulates tagged products into dot-product groups and emits each group sum, term count and overflow flag through a 2-entry result buffer with a valid/ready handshake.

Parameters:
- WIDTH, 8: multiplier operand width. Product width is 2*WIDTH.
- MUL_LAT, 2: multiplier latency in clock cycles, operand sample to product. Must be >= 1.
- ACC_W, 24: accumulator and result width. Must be >= 2*WIDTH.
- CNT_W, 8: term-counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush of the whole block.
- op_valid  in  1  operands presented to the multiplier in this cycle.
- op_last  in  1  this operand pair ends a group. Ignored unless op_valid=1.
- product  in  2*WIDTH  multiplier output, unsigned.
- res_valid  out  1  result buffer is non-empty.
- res_ready  in  1  consumer accepts the head result.
- res_sum  out  ACC_W  group sum at the buffer head.
- res_cnt  out  CNT_W  number of terms in the head group.
- res_ovf  out  1  the head group's sum wrapped.
- drop_err  out  1  sticky: a result was discarded because the buffer was full.

Behaviour:
- Reset: all registers are 0 while RST is high, taking effect immediately.
  - Outputs res_valid, res_sum, res_cnt, res_ovf and drop_err are all 0.
  - The `first` flag resets to 1.
  - RST asserted mid-group discards the partial group and all buffered results.
- Tag pipe: {op_valid, op_last} operands applied in cycle c pass through MUL_LAT registers and emerge as {t_v, t_l} in cycle c+MUL_LAT. This is the cycle in which `product` belongs to those operands.
- Accumulate, when t_v=1:
  - base = first ? 0 : acc.
  - {carry, acc_n} = base + zero-extended product, computed at ACC_W+1 bits.
  - acc <= acc_n.
  - ovf_g <= (first ? 0 : ovf_g) | carry.
  - cnt <= (first ? 1 : cnt+1), saturating at 2^CNT_W-1.
  - first <= t_l.
- Wrap-around: the sum wraps modulo 2^ACC_W, and the wrap is reported only via the ovf bit.
- When t_v=0: no change to acc, ovf_g, cnt or first.
- Group completion: when t_v & t_l, the entry {acc_n, next cnt, next ovf} is pushed into the result buffer at the same edge.
  - Result latency: res_valid rises in cycle c+MUL_LAT+1, where c is the op_last cycle.
- Result buffer: 2-entry FIFO with states EMPTY, ONE, FULL. Outputs are driven from the head register.
  - Pop when res_valid & res_ready.
  - EMPTY + push -> ONE.
  - ONE + push, no pop -> FULL.
  - ONE + pop, no push -> EMPTY.
  - ONE + push + pop -> ONE; the new entry becomes head.
  - FULL + pop -> ONE.
  - FULL + push + pop -> FULL; the pop frees a slot, so nothing is lost.
  - FULL + push, no pop -> entry discarded, drop_err <= 1.
  - res_ready while EMPTY has no effect.
- drop_err: once set, cleared only by RST or clr.
- clr: synchronous and highest priority. It zeroes the tag pipe, acc, cnt, ovf_g and the buffer, sets first=1 and clears drop_err. Operands applied in the clr cycle are discarded.
- Output stability: res_sum, res_cnt and res_ovf hold stable while res_valid=1 and res_ready=0.

Decomposition:
- Package booth_acc_pkg holds:
  - typedef prod_t (2*WIDTH bits);
  - typedef acc_t (ACC_W bits);
  - struct res_t {sum, cnt, ovf};
  - FIFO state enum {EMPTY, ONE, FULL}.
- One natural sub-module: booth_res_fifo2, the 2-entry valid/ready buffer of res_t that also generates the drop signal.
- The tag delay line and the accumulator stay inline.

Test Plan:
- Reset: assert RST asynchronously mid-cycle -> all outputs 0 immediately. Release RST, then feed one group (2,3,last) -> res_sum=6, res_cnt=1.
- 3-term group: (3,5), (7,9), (255,255,last) in cycles c..c+2 -> res_valid rises in cycle c+2+MUL_LAT+1 with res_sum=65103 (0xFE4F), res_cnt=3, res_ovf=0. Back-to-back next group (1,1,last) -> res_sum=1, res_cnt=1.
- Overflow with ACC_W=16: (255,255), (255,255,last) -> res_sum=0xFC02, res_ovf=1. The following group (2,2,last) -> res_sum=4, res_ovf=0.
- Backpressure with res_ready=0: single-term groups (1,1), (2,2), (3,3) -> buffer FULL holding 1 then 4; sum 9 is dropped and drop_err=1. Raise res_ready -> pops 1, then 4, then res_valid=0; drop_err stays 1.
- FULL with push and pop in the same cycle: hold res_ready=0 until FULL, then pulse res_ready for one cycle exactly when a new result arrives -> no drop and drop_err=0. Entries pop in order.
- clr mid-group: (10,10) then clr, then (2,2,last) -> res_sum=4, res_cnt=1. A pending buffered result is flushed and res_valid=0 the cycle after clr.
